// File: rtl/spi_pkg.sv
// spi_pkg: frame widths, controller FSM states and the peripheral register map
package spi_pkg;

    localparam int FRAME_W = 16;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP} state_e;

    localparam logic [ADDR_W-1:0] REG_OUT_LO = 7'h00;
    localparam logic [ADDR_W-1:0] REG_OUT_HI = 7'h01;
    localparam logic [ADDR_W-1:0] REG_PWM_LO = 7'h02;
    localparam logic [ADDR_W-1:0] REG_PWM_HI = 7'h03;
    localparam logic [ADDR_W-1:0] REG_DUTY   = 7'h04;

    function automatic logic [FRAME_W-1:0] pack_frame(input logic rw, input logic [ADDR_W-1:0] addr,
                                                      input logic [DATA_W-1:0] data);
        return {rw, addr, data};
    endfunction

endpackage

// File: rtl/spi_sclk_divider.sv
// spi_sclk_divider: counts CLK_DIV clk cycles per SCLK half-period and strobes the last one
module spi_sclk_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic end_o
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;

    assign end_o = en_i && (cnt_q == LAST);

    // count while enabled; restart at the end of every half-period or when disabled
    always_comb cnt_d = (en_i && !end_o) ? cnt_q + 8'd1 : 8'd0;

    // half-period counter register
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;

endmodule

// File: rtl/spi_controller.sv
// spi_controller: mode-0 SPI master sending 16-bit {rw,addr,data} frames, capturing read data
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              cs,
    output logic              sclk,
    output logic              copi,
    input  logic              cipo
);

    localparam logic [7:0] GAP_DONE = 8'(CS_GAP - 2);
    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

    state_e              state_q;
    logic [FRAME_W-1:0]  shreg_q;
    logic                rw_q;
    logic [3:0]          bit_q;
    logic [7:0]          gap_q;
    logic [DATA_W-1:0]   cap_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                cs_q, sclk_q, copi_q, done_q, busy_q, ready_q;
    logic                phase_end;

    spi_sclk_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk   (clk),
        .rst   (rst),
        .en_i  (state_q inside {SETUP, SHIFT_HI, SHIFT_LO}),
        .end_o (phase_end)
    );

    // frame sequencer: every serial output is a flop so nothing combinational reaches the pins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            rw_q      <= 1'b0;
            bit_q     <= '0;
            gap_q     <= '0;
            cap_q     <= '0;
            rd_data_q <= '0;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b0;
            copi_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: if (cmd_valid) begin
                    state_q <= SETUP;
                    shreg_q <= pack_frame(cmd_rw, cmd_addr, cmd_data);
                    rw_q    <= cmd_rw;
                    copi_q  <= cmd_rw;
                    bit_q   <= '0;
                    cs_q    <= 1'b0;
                    busy_q  <= 1'b1;
                    ready_q <= 1'b0;
                end
                SETUP: if (phase_end) begin
                    state_q <= SHIFT_HI;
                    sclk_q  <= 1'b1;
                end
                SHIFT_HI: if (phase_end) begin
                    state_q <= SHIFT_LO;
                    sclk_q  <= 1'b0;
                    shreg_q <= {shreg_q[FRAME_W-2:0], 1'b0};
                    copi_q  <= shreg_q[FRAME_W-2];
                end
                SHIFT_LO: if (phase_end) begin
                    bit_q <= bit_q + 4'd1;
                    if (bit_q == 4'd15) begin
                        state_q <= GAP;
                        cs_q    <= 1'b1;
                        gap_q   <= '0;
                    end else begin
                        state_q <= SHIFT_HI;
                        sclk_q  <= 1'b1;
                        // the rising edge about to be issued carries data bit (15-bit_q-1); capture the last eight
                        if (!rw_q && bit_q >= 4'd7) cap_q <= {cap_q[DATA_W-2:0], cipo};
                    end
                end
                GAP: begin
                    gap_q <= gap_q + 8'd1;
                    if (gap_q == GAP_DONE) begin
                        done_q <= 1'b1;
                        if (!rw_q) rd_data_q <= cap_q;
                    end
                    if (gap_q == GAP_LAST) begin
                        state_q <= IDLE;
                        gap_q   <= '0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = ready_q;
    assign done      = done_q;
    assign rd_data   = rd_data_q;
    assign busy      = busy_q;
    assign cs        = cs_q;
    assign sclk      = sclk_q;
    assign copi      = copi_q;

endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed checks of framing, read capture, back-to-back, ignore and reset behaviour
module tb_spi_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_rw = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic       cmd_ready, done, busy, cs, sclk, copi, cipo;
    logic [7:0] rd_data;

    logic       v2 = 1'b0, rw2 = 1'b0;
    logic [6:0] a2 = '0;
    logic [7:0] d2 = '0;
    logic       ready2, done2, busy2, cs2, sclk2, copi2;
    logic [7:0] rd2;

    logic [7:0] tx = '0;
    int pass_cnt = 0, total = 0;

    always #5 clk = ~clk;

    spi_controller #(.CLK_DIV(4), .CS_GAP(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .done(done), .rd_data(rd_data), .busy(busy),
        .cs(cs), .sclk(sclk), .copi(copi), .cipo(cipo)
    );

    spi_controller #(.CLK_DIV(255), .CS_GAP(4)) dut_slow (
        .clk(clk), .rst(rst), .cmd_valid(v2), .cmd_ready(ready2), .cmd_rw(rw2),
        .cmd_addr(a2), .cmd_data(d2), .done(done2), .rd_data(rd2), .busy(busy2),
        .cs(cs2), .sclk(sclk2), .copi(copi2), .cipo(1'b0)
    );

    // monitor of the fast DUT, sampled on the falling clk edge
    int rises = 0, cs_low = 0, dones = 0, gapc = 0, cs_hi = 0, gap_run = 0, fr = 0;
    logic [15:0] bits = '0, bits_at_done = '0;
    logic [7:0]  rd_at_done = '0;
    logic        prev_sclk = 1'b0, prev_cs = 1'b1;

    always @(negedge clk) begin
        if (!cs && prev_cs) begin
            fr = 0;
            gap_run = cs_hi;
        end
        cs_hi = cs ? cs_hi + 1 : 0;
        if (sclk && !prev_sclk) begin
            rises++;
            fr++;
            bits = {bits[14:0], copi};
        end
        if (!cs) cs_low++;
        if (cs && busy) gapc++;
        if (done) begin
            dones++;
            bits_at_done = bits;
            rd_at_done = rd_data;
        end
        prev_sclk = sclk;
        prev_cs = cs;
    end

    // peripheral model: data byte MSB first on rising edges 9..16, changed only after a rise
    assign cipo = (fr >= 8 && fr < 16) ? tx[3'(15 - fr)] : 1'b0;

    // monitor of the slow DUT
    int rises2 = 0, cs2_low = 0, dones2 = 0, gapc2 = 0, hi2 = 0, hi2_last = 0;
    logic [15:0] bits2 = '0;
    logic        ps2 = 1'b0;

    always @(negedge clk) begin
        if (sclk2) hi2++;
        else if (ps2) begin
            hi2_last = hi2;
            hi2 = 0;
        end
        if (sclk2 && !ps2) begin
            rises2++;
            bits2 = {bits2[14:0], copi2};
        end
        if (!cs2) cs2_low++;
        if (cs2 && busy2) gapc2++;
        if (done2) dones2++;
        ps2 = sclk2;
    end

    task automatic send(input logic rw, input logic [6:0] a, input logic [7:0] d);
        cmd_rw = rw;
        cmd_addr = a;
        cmd_data = d;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk); #1;
            if (cmd_ready && !busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #1 rst = 1'b0;
        #2;
        total++; if (cs !== 1'b1) $display("FAIL reset_cs got %b want 1", cs); else pass_cnt++;
        total++; if (sclk !== 1'b0) $display("FAIL reset_sclk got %b want 0", sclk); else pass_cnt++;
        total++; if (copi !== 1'b0) $display("FAIL reset_copi got %b want 0", copi); else pass_cnt++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        total++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", cmd_ready); else pass_cnt++;
        total++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data got %h want 00", rd_data); else pass_cnt++;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_write;
        int d0, r0, c0, g0;
        bit ok;
        d0 = dones; r0 = rises; c0 = cs_low; g0 = gapc;
        send(1'b1, 7'h04, 8'h80);
        total++; if (busy !== 1'b1 || cmd_ready !== 1'b0)
            $display("FAIL write_accept got busy=%b ready=%b want busy=1 ready=0", busy, cmd_ready); else pass_cnt++;
        total++; if (cs !== 1'b0 || sclk !== 1'b0 || copi !== 1'b1)
            $display("FAIL write_setup got cs=%b sclk=%b copi=%b want 0 0 1", cs, sclk, copi); else pass_cnt++;
        wait_idle(400, ok);
        total++; if (!ok) $display("FAIL write_timeout got no idle want idle within 400"); else pass_cnt++;
        total++; if (bits_at_done !== 16'h8480) $display("FAIL write_bits got %h want 8480", bits_at_done); else pass_cnt++;
        total++; if (cs_low - c0 != 132) $display("FAIL write_cs_low got %0d want 132", cs_low - c0); else pass_cnt++;
        total++; if (rises - r0 != 16) $display("FAIL write_rises got %0d want 16", rises - r0); else pass_cnt++;
        total++; if (dones - d0 != 1) $display("FAIL write_dones got %0d want 1", dones - d0); else pass_cnt++;
        total++; if (gapc - g0 != 8) $display("FAIL write_gap got %0d want 8", gapc - g0); else pass_cnt++;
        total++; if (rd_data !== 8'h00) $display("FAIL write_rd_data got %h want 00", rd_data); else pass_cnt++;
    endtask

    task automatic test_read;
        bit ok;
        tx = 8'hA5;
        send(1'b0, 7'h01, 8'h00);
        wait_idle(400, ok);
        total++; if (!ok) $display("FAIL read_timeout got no idle want idle within 400"); else pass_cnt++;
        total++; if (rd_at_done !== 8'hA5) $display("FAIL read_rd_at_done got %h want a5", rd_at_done); else pass_cnt++;
        total++; if (bits_at_done !== 16'h0100) $display("FAIL read_bits got %h want 0100", bits_at_done); else pass_cnt++;
        tx = 8'h3C;
        send(1'b1, 7'h00, 8'h12);
        wait_idle(400, ok);
        total++; if (!ok) $display("FAIL read_w_timeout got no idle want idle within 400"); else pass_cnt++;
        total++; if (bits_at_done !== 16'h8012) $display("FAIL read_w_bits got %h want 8012", bits_at_done); else pass_cnt++;
        total++; if (rd_data !== 8'hA5) $display("FAIL read_hold got %h want a5", rd_data); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int d0, r0;
        bit ok;
        logic [15:0] first;
        d0 = dones; r0 = rises;
        cmd_rw = 1'b1; cmd_addr = 7'h00; cmd_data = 8'hFF; cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (busy) begin ok = 1'b1; break; end
        end
        cmd_addr = 7'h02; cmd_data = 8'h0F;
        for (int i = 0; ok && i < 400; i++) begin
            @(posedge clk); #1;
            if (dones == d0 + 1) break;
            if (i == 399) ok = 1'b0;
        end
        first = bits_at_done;
        for (int i = 0; ok && i < 50; i++) begin
            @(posedge clk); #1;
            if (busy) break;
            if (i == 49) ok = 1'b0;
        end
        cmd_valid = 1'b0;
        total++; if (!ok) $display("FAIL b2b_timeout got stall want two accepted frames"); else pass_cnt++;
        wait_idle(400, ok);
        total++; if (!ok) $display("FAIL b2b_idle got no idle want idle within 400"); else pass_cnt++;
        total++; if (first !== 16'h80FF) $display("FAIL b2b_first got %h want 80ff", first); else pass_cnt++;
        total++; if (bits_at_done !== 16'h820F) $display("FAIL b2b_second got %h want 820f", bits_at_done); else pass_cnt++;
        total++; if (gap_run < 9) $display("FAIL b2b_gap got %0d want >=9", gap_run); else pass_cnt++;
        total++; if (dones - d0 != 2) $display("FAIL b2b_dones got %0d want 2", dones - d0); else pass_cnt++;
        total++; if (rises - r0 != 32) $display("FAIL b2b_rises got %0d want 32", rises - r0); else pass_cnt++;
    endtask

    task automatic test_ignore_midframe;
        int d0, r0;
        bit ok;
        d0 = dones; r0 = rises;
        send(1'b1, 7'h03, 8'h3C);
        repeat (40) @(posedge clk);
        #1;
        cmd_rw = 1'b0; cmd_addr = 7'h7F; cmd_data = 8'hFF; cmd_valid = 1'b1;
        @(posedge clk); #1;
        total++; if (cmd_ready !== 1'b0) $display("FAIL ign_ready got %b want 0", cmd_ready); else pass_cnt++;
        cmd_valid = 1'b0;
        wait_idle(400, ok);
        total++; if (!ok) $display("FAIL ign_timeout got no idle want idle within 400"); else pass_cnt++;
        repeat (30) @(posedge clk);
        #1;
        total++; if (bits_at_done !== 16'h833C) $display("FAIL ign_bits got %h want 833c", bits_at_done); else pass_cnt++;
        total++; if (dones - d0 != 1) $display("FAIL ign_dones got %0d want 1", dones - d0); else pass_cnt++;
        total++; if (rises - r0 != 16) $display("FAIL ign_rises got %0d want 16", rises - r0); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL ign_busy got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_reset_midframe;
        int d0, r0;
        bit ok;
        d0 = dones; r0 = rises;
        send(1'b1, 7'h04, 8'h55);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (rises - r0 >= 5) begin ok = 1'b1; break; end
        end
        total++; if (!ok || sclk !== 1'b1) $display("FAIL rstmid_reach got sclk=%b rises=%0d want 1 5", sclk, rises - r0); else pass_cnt++;
        rst = 1'b0;
        #1;
        total++; if (cs !== 1'b1) $display("FAIL rstmid_cs got %b want 1", cs); else pass_cnt++;
        total++; if (sclk !== 1'b0) $display("FAIL rstmid_sclk got %b want 0", sclk); else pass_cnt++;
        total++; if (busy !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL rstmid_state got busy=%b ready=%b want 0 1", busy, cmd_ready); else pass_cnt++;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        total++; if (dones != d0) $display("FAIL rstmid_no_done got %0d want 0", dones - d0); else pass_cnt++;
        r0 = rises;
        send(1'b1, 7'h02, 8'hC3);
        wait_idle(400, ok);
        total++; if (!ok) $display("FAIL rstmid_timeout got no idle want idle within 400"); else pass_cnt++;
        total++; if (bits_at_done !== 16'h82C3) $display("FAIL rstmid_bits got %h want 82c3", bits_at_done); else pass_cnt++;
        total++; if (rises - r0 != 16) $display("FAIL rstmid_rises got %0d want 16", rises - r0); else pass_cnt++;
        total++; if (dones - d0 != 1) $display("FAIL rstmid_dones got %0d want 1", dones - d0); else pass_cnt++;
    endtask

    task automatic test_slow_divider;
        int c0, r0, g0, d0;
        bit ok;
        c0 = cs2_low; r0 = rises2; g0 = gapc2; d0 = dones2;
        rw2 = 1'b1; a2 = 7'h04; d2 = 8'hAA; v2 = 1'b1;
        @(posedge clk); #1;
        v2 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk); #1;
            if (ready2 && !busy2) begin ok = 1'b1; break; end
        end
        total++; if (!ok) $display("FAIL slow_timeout got no idle want idle within 20000"); else pass_cnt++;
        total++; if (cs2_low - c0 != 8415) $display("FAIL slow_cs_low got %0d want 8415", cs2_low - c0); else pass_cnt++;
        total++; if (hi2_last != 255) $display("FAIL slow_half got %0d want 255", hi2_last); else pass_cnt++;
        total++; if (gapc2 - g0 != 4) $display("FAIL slow_gap got %0d want 4", gapc2 - g0); else pass_cnt++;
        total++; if (rises2 - r0 != 16) $display("FAIL slow_rises got %0d want 16", rises2 - r0); else pass_cnt++;
        total++; if (bits2 !== 16'h84AA) $display("FAIL slow_bits got %h want 84aa", bits2); else pass_cnt++;
        total++; if (dones2 - d0 != 1) $display("FAIL slow_dones got %0d want 1", dones2 - d0); else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_back_to_back;
        test_ignore_midframe;
        test_reset_midframe;
        test_slow_divider;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
